// File: rtl/vga_cmd_scheduler.sv
// SPI command parser and VGA update scheduler: double-buffered config committed at frame start,
// char-cell writes queued and drained during blanking. Optional macro: CMD_TIMEOUT_EN (partial-command abort).
module vga_cmd_scheduler #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] RESET_CONFIG = 32'h80FC_0000,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              frame_start,
    input  logic              active,
    output logic [31:0]       config_out,
    output logic              char_wr_en,
    output logic [ADDR_W-1:0] char_wr_addr,
    output logic [5:0]        char_wr_data,
    output logic              cfg_pending,
    output logic              overflow,
    output logic              cmd_err
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, CFG, CH_ADDR, CH_DATA} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [5:0]        data;
    } char_entry_t;

    state_t            state, state_d;
    logic [1:0]        cnt, cnt_d;
    logic              apply_c, cfg_wr_c, cfg_last_c, addr_wr_c, push_c, bad_op_c, timeout_c;
    logic [31:0]       shadow;
    logic [ADDR_W-1:0] addr_q;

    char_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              fifo_empty_c, fifo_full_c, pop_c, push_ok_c;

    // Command decode: states only move on a received byte (or a timeout abort)
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        apply_c    = 1'b0;
        cfg_wr_c   = 1'b0;
        cfg_last_c = 1'b0;
        addr_wr_c  = 1'b0;
        push_c     = 1'b0;
        bad_op_c   = 1'b0;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    case (rx_byte[7:4])
                        4'h1: begin
                            state_d = CFG;
                            cnt_d   = 2'd3;
                        end
                        4'h2:    state_d  = CH_ADDR;
                        4'h3:    apply_c  = 1'b1;
                        default: bad_op_c = 1'b1;
                    endcase
                end
                CFG: begin
                    cfg_wr_c = 1'b1;
                    if (cnt == 2'd0) begin
                        cfg_last_c = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt - 2'd1;
                    end
                end
                CH_ADDR: begin
                    addr_wr_c = 1'b1;
                    state_d   = CH_DATA;
                end
                CH_DATA: begin
                    push_c  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Shadow/commit: a commit always takes the pre-update shadow, so a 4th byte on frame_start stays pending
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= RESET_CONFIG;
            config_out  <= RESET_CONFIG;
            cfg_pending <= 1'b0;
            cmd_err     <= 1'b0;
            addr_q      <= '0;
        end else begin
            cmd_err <= bad_op_c | timeout_c;
            if (cfg_wr_c)
                shadow[{cnt, 3'b000} +: 8] <= rx_byte;
            if (apply_c || (frame_start && cfg_pending))
                config_out <= shadow;
            if (cfg_last_c)
                cfg_pending <= 1'b1;
            else if (apply_c || frame_start)
                cfg_pending <= 1'b0;
            if (addr_wr_c)
                addr_q <= ADDR_W'(rx_byte);
        end
    end

    assign fifo_empty_c = (wr_ptr == rd_ptr);
    assign fifo_full_c  = ((wr_ptr - rd_ptr) == PTR_W'(FIFO_DEPTH));
    assign pop_c        = !active && !fifo_empty_c;
    assign push_ok_c    = push_c && (!fifo_full_c || pop_c);

    always_ff @(posedge clk) begin
        if (!rst && push_ok_c)
            mem[wr_ptr[IDX_W-1:0]] <= '{addr: addr_q, data: rx_byte[5:0]};
    end

    // Drain only in blanking; the strobe follows the pop by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            char_wr_en   <= 1'b0;
            char_wr_addr <= '0;
            char_wr_data <= '0;
        end else begin
            char_wr_en <= pop_c;
            if (pop_c) begin
                char_wr_addr <= mem[rd_ptr[IDX_W-1:0]].addr;
                char_wr_data <= mem[rd_ptr[IDX_W-1:0]].data;
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            if (push_ok_c)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (push_c && !push_ok_c)
                overflow <= 1'b1;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || rx_valid || state == IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout_c = (state != IDLE) && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_c      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_cmd_scheduler.sv
// Self-checking bench for vga_cmd_scheduler: config commit timing, char queue drain/overflow,
// opcode errors and reset abort; char writes are checked against a scoreboard queue.
module tb_vga_cmd_scheduler;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 1024;
    localparam logic [31:0] RST_CFG     = 32'h80FC_0000;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              frame_start;
    logic              active;
    logic [31:0]       config_out;
    logic              char_wr_en;
    logic [ADDR_W-1:0] char_wr_addr;
    logic [5:0]        char_wr_data;
    logic              cfg_pending;
    logic              overflow;
    logic              cmd_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_total = 0;
    int          base;
    logic        last_active = 1'b1;
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;

    vga_cmd_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_start  (frame_start),
        .active       (active),
        .config_out   (config_out),
        .char_wr_en   (char_wr_en),
        .char_wr_addr (char_wr_addr),
        .char_wr_data (char_wr_data),
        .cfg_pending  (cfg_pending),
        .overflow     (overflow),
        .cmd_err      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && char_wr_en) begin
            wr_total++;
            check("wr_during_active", 64'(last_active), 64'd0);
            if (exp_q.size() == 0) begin
                check("wr_spurious", 64'({char_wr_addr, char_wr_data}), 64'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_entry", 64'({char_wr_addr, char_wr_data}), 64'(mon_e));
            end
        end
        last_active = active;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fs = 1'b0);
        @(posedge clk);
        #1;
        rx_byte     = b;
        rx_valid    = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        rx_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] a, input logic [5:0] d, input logic keep);
        send_byte(8'h20);
        send_byte(a);
        send_byte({2'b00, d});
        if (keep)
            exp_q.push_back({a, d});
    endtask

    task automatic pulse_fs;
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic drain(input int n_exp, input int from);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            @(posedge clk);
        cycles(4);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_count", 64'(wr_total - from), 64'(n_exp));
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; frame_start = 1'b0; active = 1'b1;
        cycles(3);
        rst = 1'b0;

        check("rst_config", 64'(config_out), 64'(RST_CFG));
        check("rst_wr_en", 64'(char_wr_en), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_pending", 64'(cfg_pending), 64'd0);
        check("rst_cmd_err", 64'(cmd_err), 64'd0);

        // SET_CFG then frame_start commit
        send_byte(8'h10); send_byte(8'hC0); send_byte(8'h12);
        check("cfg_partial", 64'(config_out), 64'(RST_CFG));
        send_byte(8'h34); send_byte(8'h56);
        check("cfg_pending_set", 64'(cfg_pending), 64'd1);
        check("cfg_not_committed", 64'(config_out), 64'(RST_CFG));
        pulse_fs;
        check("cfg_commit", 64'(config_out), 64'h0000_0000_C012_3456);
        check("cfg_pending_clr", 64'(cfg_pending), 64'd0);
        pulse_fs;
        check("fs_no_pending", 64'(config_out), 64'h0000_0000_C012_3456);

        // Char write held while active, drained in blanking
        base = wr_total;
        send_char(8'h05, 6'h2A, 1'b1);
        cycles(10);
        check("char_held", 64'(wr_total - base), 64'd0);
        active = 1'b0;
        drain(1, base);

        // Five writes into a depth-4 queue
        active = 1'b1;
        base = wr_total;
        for (int i = 0; i < 4; i++)
            send_char(8'h10 + 8'(i), 6'(i * 3 + 1), 1'b1);
        check("ovf_at_full", 64'(overflow), 64'd0);
        send_char(8'h99, 6'h3F, 1'b0);
        check("ovf_set", 64'(overflow), 64'd1);
        active = 1'b0;
        drain(4, base);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Last SET_CFG byte coincident with frame_start commits the pre-update shadow
        send_byte(8'h10); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("sim_pending_a", 64'(cfg_pending), 64'd1);
        send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD, 1'b1);
        check("sim_old_commit", 64'(config_out), 64'h0000_0000_AABB_CC44);
        check("sim_still_pending", 64'(cfg_pending), 64'd1);
        send_byte(8'h30);
        check("apply_new", 64'(config_out), 64'h0000_0000_AABB_CCDD);
        check("apply_pending_clr", 64'(cfg_pending), 64'd0);

        // APPLY coincident with frame_start
        send_byte(8'h10); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h30, 1'b1);
        check("apply_fs_commit", 64'(config_out), 64'h0000_0000_0102_0304);
        check("apply_fs_pending", 64'(cfg_pending), 64'd0);

        // Unknown opcodes
        send_byte(8'h7F);
        check("bad_op_pulse", 64'(cmd_err), 64'd1);
        cycles(1);
        check("bad_op_single", 64'(cmd_err), 64'd0);
        send_byte(8'h05);
        check("bad_op_zero", 64'(cmd_err), 64'd1);

        // Reset mid-command flushes queue and restores shadow
        active = 1'b1;
        send_char(8'h03, 6'h15, 1'b0);
        send_byte(8'h10); send_byte(8'h55);
        do_reset;
        check("mid_rst_config", 64'(config_out), 64'(RST_CFG));
        check("mid_rst_pending", 64'(cfg_pending), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        active = 1'b0;
        base = wr_total;
        cycles(10);
        check("mid_rst_flushed", 64'(wr_total - base), 64'd0);
        send_byte(8'h30);
        check("mid_rst_shadow", 64'(config_out), 64'(RST_CFG));

        // Push and pop on the same cycle with a full queue
        active = 1'b1;
        base = wr_total;
        for (int i = 0; i < 4; i++)
            send_char(8'h40 + 8'(i), 6'(i + 8), 1'b1);
        send_byte(8'h20);
        send_byte(8'h77);
        @(posedge clk);
        #1;
        rx_byte  = 8'h25;
        rx_valid = 1'b1;
        active   = 1'b0;
        exp_q.push_back({8'h77, 6'h25});
        @(posedge clk);
        #1 rx_valid = 1'b0;
        drain(5, base);
        check("pushpop_no_ovf", 64'(overflow), 64'd0);

`ifdef CMD_TIMEOUT_EN
        begin
            int errs;
            errs = 0;
            send_byte(8'h10); send_byte(8'hAA);
            for (int i = 0; i < int'(TIMEOUT_CYC) + 8; i++) begin
                @(posedge clk);
                #1;
                if (cmd_err)
                    errs++;
            end
            check("timeout_pulse", 64'(errs), 64'd1);
            send_byte(8'h30);
            check("timeout_partial", 64'(config_out[31:24]), 64'hAA);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
